// File: rtl/mac_pkg.sv
// mac_pkg -- shared definitions for the mac neuron core load sequencer.
//
// Contents:
//   MAC_NW / MAC_PW  : weights (and activations) per vector, and pointer width
//   MAC_DW / MAC_OW  : default byte width and accumulator width
//   mac_seq_state_e  : sequencer state encoding
//   ptr_onehot()     : one-hot decode of a weight pointer to ld1..ld4
package mac_pkg;

  localparam int MAC_NW = 4;
  localparam int MAC_PW = $clog2(MAC_NW);
  localparam int MAC_DW = 8;
  localparam int MAC_OW = 16;

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_W_LD   = 3'd2,
    S_X_LD   = 3'd3,
    S_X_ACC  = 3'd4,
    S_SETTLE = 3'd5,
    S_RESULT = 3'd6
  } mac_seq_state_e;

  // Weight slot index -> one-hot load strobe vector (bit 0 = ld1).
  function automatic logic [MAC_NW-1:0] ptr_onehot(input logic [MAC_PW-1:0] ptr);
    ptr_onehot      = '0;
    ptr_onehot[ptr] = 1'b1;
  endfunction

endpackage

// File: rtl/mac_seq.sv
// mac_seq -- load sequencer for the mac neuron core.
//
// Turns a host byte stream (weights / activations) into the core's one-hot
// load strobes, accumulate enables and reset. After the fourth activation it
// waits SETTLE cycles, captures the accumulator and offers it on a
// valid/ready result port.
//
// Optional feature macro: MAC_SEQ_RELU_EN -- when defined, the captured
// result is clamped to zero if the signed accumulator is negative.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_valid/s_ready     : host byte handshake
//   s_data, s_kind      : byte and its kind (1 = weight, 0 = activation)
//   r_valid/r_ready     : result handshake
//   r_data              : captured result, stable while r_valid
//   mac_in              : data to core, held until the next accepted byte
//   mac_ld, mac_ld1..4  : one-cycle activation / weight load strobes
//   mac_clken           : one-cycle accumulate enable
//   mac_rst             : active-high core reset
//   mac_out             : core accumulator
//
// All outputs come straight from flops; the next-cycle output values are
// decoded from the next state so strobes land in the state they belong to.
module mac_seq
  import mac_pkg::*;
#(
  parameter int DW     = MAC_DW,
  parameter int OW     = MAC_OW,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_kind,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [OW-1:0] r_data,
  output logic [DW-1:0] mac_in,
  output logic          mac_ld,
  output logic          mac_ld1,
  output logic          mac_ld2,
  output logic          mac_ld3,
  output logic          mac_ld4,
  output logic          mac_clken,
  output logic          mac_rst,
  input  logic [OW-1:0] mac_out
);

  localparam int                SCW         = 4;
  localparam logic [SCW-1:0]    SETTLE_LOAD = SCW'(SETTLE - 1);
  localparam logic [MAC_PW-1:0] X_LAST      = MAC_PW'(MAC_NW - 1);

  mac_seq_state_e    state_r;
  mac_seq_state_e    state_nx_s;
  logic [MAC_PW-1:0] w_ptr_r;
  logic [MAC_PW-1:0] w_ptr_nx_s;
  logic [MAC_PW-1:0] x_cnt_r;
  logic [MAC_PW-1:0] x_cnt_nx_s;
  logic [SCW-1:0]    settle_r;
  logic [SCW-1:0]    settle_nx_s;
  logic [DW-1:0]     mac_in_r;
  logic [DW-1:0]     mac_in_nx_s;
  logic [OW-1:0]     r_data_r;
  logic [OW-1:0]     r_data_nx_s;

  logic              s_ready_r;
  logic              r_valid_r;
  logic              ld_r;
  logic [MAC_NW-1:0] ldw_r;
  logic              clken_r;
  logic              mac_rst_r;

  // Result capture transform; the negative clamp only exists in the ReLU build.
  function automatic logic [OW-1:0] capture(input logic [OW-1:0] acc);
`ifdef MAC_SEQ_RELU_EN
    if (acc[OW-1]) begin
      capture = '0;
    end else begin
      capture = acc;
    end
`else
    capture = acc;
`endif
  endfunction

  // Next-state, counter and data-path logic.
  always_comb begin
    state_nx_s  = state_r;
    w_ptr_nx_s  = w_ptr_r;
    x_cnt_nx_s  = x_cnt_r;
    settle_nx_s = settle_r;
    mac_in_nx_s = mac_in_r;
    r_data_nx_s = r_data_r;
    case (state_r)
      S_CLEAR: begin
        w_ptr_nx_s  = '0;
        x_cnt_nx_s  = '0;
        settle_nx_s = '0;
        state_nx_s  = S_IDLE;
      end
      S_IDLE: begin
        if (s_valid) begin
          mac_in_nx_s = s_data;
          if (s_kind) begin
            state_nx_s = S_W_LD;
          end else begin
            state_nx_s = S_X_LD;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_W_LD: begin
        // Pointer wraps, so a fifth weight overwrites slot 1.
        w_ptr_nx_s = w_ptr_r + MAC_PW'(1);
        state_nx_s = S_IDLE;
      end
      S_X_LD: begin
        state_nx_s = S_X_ACC;
      end
      S_X_ACC: begin
        x_cnt_nx_s = x_cnt_r + MAC_PW'(1);
        if (x_cnt_r == X_LAST) begin
          settle_nx_s = SETTLE_LOAD;
          state_nx_s  = S_SETTLE;
        end else begin
          state_nx_s  = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (settle_r == '0) begin
          r_data_nx_s = capture(mac_out);
          state_nx_s  = S_RESULT;
        end else begin
          settle_nx_s = settle_r - SCW'(1);
        end
      end
      S_RESULT: begin
        if (r_ready) begin
          state_nx_s = S_CLEAR;
        end else begin
          state_nx_s = S_RESULT;
        end
      end
      default: begin
        state_nx_s = S_CLEAR;
      end
    endcase
  end

  // State, counters and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_CLEAR;
      w_ptr_r  <= '0;
      x_cnt_r  <= '0;
      settle_r <= '0;
      mac_in_r <= '0;
      r_data_r <= '0;
    end else begin
      state_r  <= state_nx_s;
      w_ptr_r  <= w_ptr_nx_s;
      x_cnt_r  <= x_cnt_nx_s;
      settle_r <= settle_nx_s;
      mac_in_r <= mac_in_nx_s;
      r_data_r <= r_data_nx_s;
    end
  end

  // Registered control outputs decoded from the next state (mutually exclusive).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_r <= 1'b0;
      r_valid_r <= 1'b0;
      ld_r      <= 1'b0;
      ldw_r     <= '0;
      clken_r   <= 1'b0;
      mac_rst_r <= 1'b1;
    end else begin
      s_ready_r <= (state_nx_s == S_IDLE);
      r_valid_r <= (state_nx_s == S_RESULT);
      ld_r      <= (state_nx_s == S_X_LD);
      // w_ptr_r still holds the slot for this weight; it advances on leaving W_LD.
      ldw_r     <= (state_nx_s == S_W_LD) ? ptr_onehot(w_ptr_r) : '0;
      clken_r   <= (state_nx_s == S_X_ACC);
      mac_rst_r <= (state_nx_s == S_CLEAR);
    end
  end

  assign s_ready   = s_ready_r;
  assign r_valid   = r_valid_r;
  assign r_data    = r_data_r;
  assign mac_in    = mac_in_r;
  assign mac_ld    = ld_r;
  assign mac_ld1   = ldw_r[0];
  assign mac_ld2   = ldw_r[1];
  assign mac_ld3   = ldw_r[2];
  assign mac_ld4   = ldw_r[3];
  assign mac_clken = clken_r;
  assign mac_rst   = mac_rst_r;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq -- self-checking bench for mac_seq.
// A small behavioural mac core reacts to the DUT strobes and drives mac_out;
// an independent transaction-level reference (weight slots + running sum)
// predicts each result. Directed steps first, then randomized vectors.
module tb_mac_seq;
  import mac_pkg::*;

  localparam int DW     = 8;
  localparam int OW     = 16;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_kind = 1'b0;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic [OW-1:0] r_data;
  logic [DW-1:0] mac_in;
  logic          mac_ld, mac_ld1, mac_ld2, mac_ld3, mac_ld4;
  logic          mac_clken, mac_rst;
  logic [OW-1:0] mac_out = '0;

  always #5 clk = ~clk;

  mac_seq #(.DW(DW), .OW(OW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_kind(s_kind),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .mac_in(mac_in), .mac_ld(mac_ld),
    .mac_ld1(mac_ld1), .mac_ld2(mac_ld2), .mac_ld3(mac_ld3), .mac_ld4(mac_ld4),
    .mac_clken(mac_clken), .mac_rst(mac_rst), .mac_out(mac_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural core
  logic [7:0]  core_w [4];
  logic [7:0]  core_x;
  int          core_k;
  logic [15:0] core_acc;

  // transaction-level reference
  logic [7:0]  ref_slot [4];
  int          ref_p, ref_k;
  logic [15:0] ref_acc;
  logic [15:0] exp_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  function automatic logic [15:0] expect_res(input logic [15:0] a);
`ifdef MAC_SEQ_RELU_EN
    return a[15] ? 16'h0000 : a;
`else
    return a;
`endif
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 4; i++) ref_slot[i] = 8'h00;
    ref_p = 0; ref_k = 0; ref_acc = 16'h0000;
  endtask

  // One clock: check strobe exclusivity, let the core react to this cycle's
  // strobes, then move to 1 time unit after the next rising edge.
  task automatic tick();
    logic [3:0] ldw;
    logic       ld, ck, rs;
    logic [7:0] din;
    ldw = {mac_ld4, mac_ld3, mac_ld2, mac_ld1};
    ld = mac_ld; ck = mac_clken; rs = mac_rst; din = mac_in;
    check("strobe_onehot", 32'($countones({ldw, ld, ck, rs}) <= 1), 32'd1);
    @(posedge clk);
    #1;
    if (rs) begin
      for (int i = 0; i < 4; i++) core_w[i] = 8'h00;
      core_acc = 16'h0000; core_k = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (ldw[i]) core_w[i] = din;
      if (ld) core_x = din;
      if (ck) begin
        core_acc = core_acc + smul(core_w[core_k], core_x);
        core_k = (core_k + 1) % 4;
      end
    end
    mac_out = core_acc;
  endtask

  // Offer one byte after `gap` idle cycles and check the resulting sequence.
  task automatic send(input logic kind, input logic [7:0] data, input int gap);
    int budget;
    repeat (gap) tick();
    s_valid = 1'b1; s_kind = kind; s_data = data;
    budget = 0;
    while (!s_ready && budget < 50) begin
      tick();
      budget++;
    end
    check("accept_wait", 32'(budget < 50), 32'd1);
    tick();
    s_valid = 1'b0; s_kind = 1'b0; s_data = 8'($urandom);
    check("mac_in", 32'(mac_in), 32'(data));
    if (kind) begin
      check("ld_slot", 32'({mac_ld4, mac_ld3, mac_ld2, mac_ld1}), 32'(1 << ref_p));
      check("ld_w_no_x", 32'(mac_ld), 32'd0);
      ref_slot[ref_p] = data;
      ref_p = (ref_p + 1) % 4;
      tick();
      check("w_ready_back", 32'(s_ready), 32'd1);
    end else begin
      check("x_ld", 32'(mac_ld), 32'd1);
      check("x_no_w", 32'({mac_ld4, mac_ld3, mac_ld2, mac_ld1}), 32'd0);
      tick();
      check("x_clken", 32'(mac_clken), 32'd1);
      check("mac_in_hold", 32'(mac_in), 32'(data));
      ref_acc = ref_acc + smul(ref_slot[ref_k], data);
      ref_k++;
      if (ref_k < 4) begin
        tick();
        check("x_ready_back", 32'(s_ready), 32'd1);
      end else begin
        for (int i = 1; i <= SETTLE + 1; i++) begin
          tick();
          if (i <= SETTLE) check("settle_no_valid", 32'(r_valid), 32'd0);
          else check("r_valid_latency", 32'(r_valid), 32'd1);
        end
        exp_res = expect_res(ref_acc);
        check("r_data", 32'(r_data), 32'(exp_res));
      end
    end
  endtask

  // Hold the result for `hold` cycles, then take it and check the clear.
  task automatic consume(input int hold);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(r_valid), 32'd1);
      check("hold_data", 32'(r_data), 32'(exp_res));
      check("hold_backpressure", 32'(s_ready), 32'd0);
      tick();
    end
    check("pre_hs_valid", 32'(r_valid), 32'd1);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("hs_valid_drop", 32'(r_valid), 32'd0);
    check("hs_mac_rst", 32'(mac_rst), 32'd1);
    tick();
    check("hs_ready", 32'(s_ready), 32'd1);
    check("hs_rst_one_cycle", 32'(mac_rst), 32'd0);
    ref_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) core_w[i] = 8'h00;
    core_x = 8'h00; core_k = 0; core_acc = 16'h0000;
    ref_clear();
    exp_res = 16'h0000;

    // reset state
    repeat (3) tick();
    check("rst_mac_rst", 32'(mac_rst), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_strobes", 32'({mac_ld, mac_ld1, mac_ld2, mac_ld3, mac_ld4, mac_clken}), 32'd0);
    check("rst_mac_in", 32'(mac_in), 32'd0);
    check("rst_r_data", 32'(r_data), 32'd0);

    // release: one CLEAR cycle then IDLE
    rst_n = 1'b1;
    check("rel_clear", 32'(mac_rst), 32'd1);
    tick();
    check("rel_idle_ready", 32'(s_ready), 32'd1);
    check("rel_idle_rst", 32'(mac_rst), 32'd0);
    check("rel_idle_valid", 32'(r_valid), 32'd0);

    // basic vector: 1*5 + 2*6 + 3*7 + 4*8 = 70
    for (int i = 1; i <= 4; i++) send(1'b1, 8'(i), 0);
    for (int i = 5; i <= 8; i++) send(1'b0, 8'(i), 0);
    check("r_data_70", 32'(r_data), 32'h0046);
    consume(10);

    // five weights: the fifth wraps onto ld1
    for (int i = 0; i < 5; i++) send(1'b1, 8'(8'h11 + i), 1);
    for (int i = 0; i < 4; i++) send(1'b0, 8'($urandom), 0);
    consume(2);

    // negative accumulator: 4 * (-1 * 50) = -200
    for (int i = 0; i < 4; i++) send(1'b1, 8'hFF, 0);
    for (int i = 0; i < 4; i++) send(1'b0, 8'd50, 0);
`ifdef MAC_SEQ_RELU_EN
    check("relu_neg", 32'(r_data), 32'h0000);
`else
    check("relu_neg", 32'(r_data), 32'hFF38);
`endif
    consume(1);

    // reset during X_ACC of the third activation
    for (int i = 1; i <= 4; i++) send(1'b1, 8'(i), 0);
    send(1'b0, 8'h09, 0);
    send(1'b0, 8'h0A, 0);
    s_valid = 1'b1; s_kind = 1'b0; s_data = 8'h0B;
    tick();
    s_valid = 1'b0;
    check("abort_x_ld", 32'(mac_ld), 32'd1);
    tick();
    check("abort_x_acc", 32'(mac_clken), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mac_rst", 32'(mac_rst), 32'd1);
    check("abort_outputs", 32'({mac_ld, mac_ld1, mac_ld2, mac_ld3, mac_ld4, mac_clken, s_ready, r_valid}), 32'd0);
    check("abort_mac_in", 32'(mac_in), 32'd0);
    check("abort_r_data", 32'(r_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    ref_clear();
    check("abort_rel_clear", 32'(mac_rst), 32'd1);
    tick();
    check("abort_rel_idle", 32'(s_ready), 32'd1);
    check("abort_no_stale_valid", 32'(r_valid), 32'd0);
    for (int i = 1; i <= 4; i++) send(1'b1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 4; i++) send(1'b0, 8'($urandom), 0);
    consume(0);

    // randomized vectors with interleaved weights and gaps
    for (int v = 0; v < 10; v++) begin
      for (int a = 0; a < 4; a++) begin
        int nw;
        nw = int'($urandom_range(0, 2));
        for (int w = 0; w < nw; w++) send(1'b1, 8'($urandom), int'($urandom_range(0, 3)));
        send(1'b0, 8'($urandom), int'($urandom_range(0, 3)));
      end
      consume(int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
